axi4lite_uart_master: RTL and testbench

AXI4LITE_UART_MASTER -- requirements
Module: axi4lite_uart_master

---
 rtl/axi4lite_pkg.sv | 23 ++
 rtl/axi4lite_uart_master.sv | 153 +++++++++++++++
 tb/tb_axi4lite_uart_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes, FSM state encoding and a saturating counter helper
// for the UART command-to-AXI bridge.
package axi4lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_RA   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axi4lite_uart_master.sv
// Single-outstanding command-to-AXI4-Lite master driving the UART slave port.
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | AW and W presented, each dropped after its own handshake
// WB    | waiting for write response
// RA    | AR presented until arready
// RD    | waiting for read data
// RSP   | response held until rsp_ready
module axi4lite_uart_master
    import axi4lite_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 5,
    parameter int AXI4_RDATA_WIDTH   = 32,
    parameter int AXI4_WDATA_WIDTH   = 32,
    parameter int AXI4_PROT_WIDTH    = 3
) (
    input  logic                            clk,
    input  logic                            wb_rst_i,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_we,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   cmd_addr,
    input  logic [AXI4_WDATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI4_WDATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [AXI4_RDATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_we,
    output logic [7:0]                      err_cnt,
    output logic                            m_axi_awvalid,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI4_PROT_WIDTH-1:0]      m_axi_awprot,
    input  logic                            m_axi_awready,
    output logic                            m_axi_wvalid,
    output logic [AXI4_WDATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI4_WDATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                            m_axi_wready,
    input  logic                            m_axi_bvalid,
    input  logic [1:0]                      m_axi_bresp,
    output logic                            m_axi_bready,
    output logic                            m_axi_arvalid,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   m_axi_araddr,
    output logic [AXI4_PROT_WIDTH-1:0]      m_axi_arprot,
    input  logic                            m_axi_arready,
    input  logic                            m_axi_rvalid,
    input  logic [AXI4_RDATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    output logic                            m_axi_rready
);

    logic [2:0]                     state_q, state_d;
    logic [AXI4_ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [AXI4_WDATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [AXI4_WDATA_WIDTH/8-1:0]  wstrb_q, wstrb_d;
    logic                           we_q, we_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic [AXI4_RDATA_WIDTH-1:0]    rdata_q, rdata_d;
    axi_resp_t                      resp_q, resp_d;
    logic [7:0]                     err_q, err_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                we_d      = cmd_we;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd_we ? ST_WR : ST_RA;
            end
            ST_WR: begin
                // The two channels complete independently, in either order.
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) state_d = ST_WB;
            end
            ST_WB: if (m_axi_bvalid) begin
                rdata_d = '0;
                resp_d  = m_axi_bresp;
                if (m_axi_bresp != RESP_OKAY) err_d = sat_inc8(err_q);
                state_d = ST_RSP;
            end
            ST_RA: if (m_axi_arready) state_d = ST_RD;
            ST_RD: if (m_axi_rvalid) begin
                rdata_d = m_axi_rdata;
                resp_d  = m_axi_rresp;
                if (m_axi_rresp != RESP_OKAY) err_d = sat_inc8(err_q);
                state_d = ST_RSP;
            end
            ST_RSP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_we        = we_q;
    assign err_cnt       = err_q;

    assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = '0;
    assign m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == ST_WB);
    assign m_axi_arvalid = (state_q == ST_RA);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = '0;
    assign m_axi_rready  = (state_q == ST_RD);

endmodule

// File: tb/tb_axi4lite_uart_master.sv
// Directed bench for axi4lite_uart_master: behavioural AXI slave, response scoreboard
// and per-cycle channel stability monitor.
module tb_axi4lite_uart_master;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic        rvalid = 1'b0, rready;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic b_en = 1'b1, r_en = 1'b1, stray_b = 1'b0, stray_r = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;

    int n_checks = 0, n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    axi4lite_uart_master dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_we(rsp_we), .err_cnt(err_cnt),
        .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arready(arready),
        .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rready(rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: each ready rises after its valid has been seen for <delay> cycles.
    initial forever begin
        @(negedge clk); #1;
        if (awvalid) begin awready = (aw_seen == aw_delay); aw_seen++; end
        else begin awready = 1'b0; aw_seen = 0; end
        if (wvalid) begin wready = (w_seen == w_delay); w_seen++; end
        else begin wready = 1'b0; w_seen = 0; end
        if (arvalid) begin arready = (ar_seen == ar_delay); ar_seen++; end
        else begin arready = 1'b0; ar_seen = 0; end
        bvalid = (bready && b_en) || stray_b;
        bresp  = b_resp_cfg;
        rvalid = (rready && r_en) || stray_r;
        rdata  = r_data_cfg;
        rresp  = r_resp_cfg;
    end

    initial forever begin
        @(negedge clk); #2;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rdata", rsp_rdata, e.rdata);
                check("sb_resp", 32'(rsp_resp), 32'(e.resp));
                check("sb_we", 32'(rsp_we), 32'(e.we));
            end
        end
    end

    // Valid must hold with stable payload until its ready; prot always zero.
    initial begin
        logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr, p_rst;
        logic [4:0] p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        logic [3:0] p_wstrb;
        p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0; p_ar = 0; p_arr = 0; p_rst = 1;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk); #2;
            if (!p_rst && p_aw && !p_awr) begin
                check("aw_hold", 32'(awvalid), 32'd1);
                check("aw_addr_stable", 32'(awaddr), 32'(p_awaddr));
            end
            if (!p_rst && p_w && !p_wr) begin
                check("w_hold", 32'(wvalid), 32'd1);
                check("w_data_stable", wdata, p_wdata);
                check("w_strb_stable", 32'(wstrb), 32'(p_wstrb));
            end
            if (!p_rst && p_ar && !p_arr) begin
                check("ar_hold", 32'(arvalid), 32'd1);
                check("ar_addr_stable", 32'(araddr), 32'(p_araddr));
            end
            if (awvalid) check("awprot_zero", 32'(awprot), 32'd0);
            if (arvalid) check("arprot_zero", 32'(arprot), 32'd0);
            p_aw = awvalid; p_awr = awready; p_w = wvalid; p_wr = wready;
            p_ar = arvalid; p_arr = arready; p_rst = wb_rst_i;
            p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
        end
    end

    // Returns at the negedge of cycle 1 (first cycle after acceptance).
    task automatic do_cmd(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic push,
                          input logic [31:0] e_rdata, input logic [1:0] e_resp);
        int n;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        if (push) begin
            e.rdata = e_rdata; e.resp = e_resp; e.we = we;
            sb_q.push_back(e);
        end
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("cmd_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_axi_vr", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        check("rst_rsp", {rsp_valid, rsp_we, rsp_resp, rsp_rdata[27:0]}, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Zero-wait write
        do_cmd(1'b1, 5'h0C, 32'h3, 4'b0001, 1'b1, 32'h0, 2'b00);
        check("w0_c1_aw_w_valid", 32'({awvalid, wvalid, bready}), 32'b110);
        check("w0_c1_awaddr", 32'(awaddr), 32'h0C);
        check("w0_c1_wdata", wdata, 32'h3);
        check("w0_c1_wstrb", 32'(wstrb), 32'b0001);
        @(negedge clk);
        check("w0_c2_bready", 32'({awvalid, wvalid, bready}), 32'b001);
        @(negedge clk);
        check("w0_c3_rsp", 32'({rsp_valid, rsp_we, rsp_resp}), 32'b1100);

        // Read with arready delayed 3 cycles
        ar_delay = 3; r_data_cfg = 32'h60;
        do_cmd(1'b0, 5'h14, 32'h0, 4'h0, 1'b1, 32'h60, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            check("r0_arvalid_held", 32'(arvalid), 32'd1);
            check("r0_araddr", 32'(araddr), 32'h14);
        end
        @(negedge clk);
        check("r0_c5_ar_drop_rready", 32'({arvalid, rready}), 32'b01);
        @(negedge clk);
        check("r0_c6_rsp", 32'({rsp_valid, rsp_we}), 32'b10);
        check("r0_c6_rdata", rsp_rdata, 32'h60);
        ar_delay = 0;

        // Write with awready at cycle 1, wready at cycle 6
        w_delay = 5;
        do_cmd(1'b1, 5'h04, 32'hA5, 4'hF, 1'b1, 32'h0, 2'b00);
        check("w1_c1_valids", 32'({awvalid, wvalid}), 32'b11);
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            check("w1_split_wait", 32'({awvalid, wvalid, bready}), 32'b010);
        end
        @(negedge clk);
        check("w1_c7_bready", 32'({awvalid, wvalid, bready}), 32'b001);
        w_delay = 0;
        wait_idle();
        check("err_cnt_after_okay", 32'(err_cnt), 32'd0);

        // Non-OKAY read response counts as an error
        r_resp_cfg = 2'b01; r_data_cfg = 32'h1234_5678;
        do_cmd(1'b0, 5'h10, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 2'b01);
        wait_idle();
        check("err_cnt_exokay", 32'(err_cnt), 32'd1);
        r_resp_cfg = 2'b00;

        // Response back-pressure with a stray bvalid during RSP
        rsp_ready = 1'b0; r_data_cfg = 32'hDEAD_BEEF;
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 2'b00);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("stall_rsp_timeout", 32'd1, 32'd0);
        stray_b = 1'b1; b_resp_cfg = 2'b10;
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_valid", 32'({rsp_valid, cmd_ready}), 32'b10);
            check("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("stall_resp_we", 32'({rsp_resp, rsp_we}), 32'd0);
            @(negedge clk);
        end
        stray_b = 1'b0; b_resp_cfg = 2'b00;
        check("stray_b_ignored", 32'(err_cnt), 32'd1);
        rsp_ready = 1'b1;
        check("cmd_ready_same_cycle", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_next_cycle", 32'(cmd_ready), 32'd1);

        // Reset while in RD, then late rvalid
        r_en = 1'b0;
        do_cmd(1'b0, 5'h1C, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        check("rst_mid_rready", 32'(rready), 32'd1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        wb_rst_i = 1'b0;
        check("rst_mid_axi_vr", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        r_en = 1'b1; stray_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_rvalid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        stray_r = 1'b0;

        // 256 consecutive SLVERR writes saturate the error counter
        b_resp_cfg = 2'b10;
        for (int i = 1; i <= 256; i++) begin
            do_cmd(1'b1, 5'h00, 32'(i), 4'b0001, 1'b1, 32'h0, 2'b10);
            wait_idle();
            if (i == 1) check("err_cnt_1", 32'(err_cnt), 32'd1);
            if (i == 254) check("err_cnt_254", 32'(err_cnt), 32'd254);
            if (i >= 255) check("err_cnt_sat", 32'(err_cnt), 32'd255);
        end
        b_resp_cfg = 2'b00;

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
